control_unit: RTL
=================

# control_unit

Multi-cycle control FSM for the RV32 core: sole driver of the ALU's opcode/funct3/funct7 inputs and sole consumer of its is_zero/is_less flags. Owns the instruction register (IR) and immediate generator, sequences FETCH/DECODE/EXECUTE/MEM_WAIT/WRITEBACK, and drives datapath mux selects, register-file and PC write strobes, and the unified memory request handshake.

## Interface
- DATA_WIDTH, params_pkg::DATA_WIDTH (32): instruction/immediate width.
- OPCODE_WIDTH, params_pkg::OPCODE_WIDTH: width of the opcode enum.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous, active-low reset.
- mem_rdata_i  in  32  memory read data, valid when mem_rvalid_i=1.
- mem_rvalid_i  in  1  read data valid / store acknowledge.
- is_zero_i, is_less_i  in  1 each  ALU flags (signed compare of a-b).
- mem_req_o, mem_we_o  out  1 each  memory request / write enable.
- mem_addr_sel_o  out  1  0=PC, 1=ALUOUT.
- opcode_o  out  opcode  ALU opcode; funct3_o out 3, funct7_o out 7.
- src_a_sel_o  out  2  00=PC, 01=OLD_PC, 10=RS1, 11=ZERO.
- src_b_sel_o  out  2  00=RS2, 01=IMM, 10=FOUR.
- imm_o  out  32  decoded immediate from IR.
- rs1_o, rs2_o, rd_o  out  5 each  IR[19:15], IR[24:20], IR[11:7].
- ir_we_o  out  1  datapath captures OLD_PC<=PC.
- pc_we_o  out  1; pc_src_o out 1 (0=ALU result, 1=ALUOUT register).
- reg_we_o  out  1; wb_sel_o out 1 (0=ALUOUT, 1=MDR).
- halt_o, illegal_o  out  1 each  sticky halt / illegal-instruction flag.

## Operation
- Datapath latches ALUOUT every cycle and MDR on mem_rvalid_i.
- Default (any state unless overridden): opcode_o=LOAD (sum), funct3_o=0, funct7_o=0, all strobes 0, selects 0.
- FETCH: mem_req_o=1, addr_sel=PC, we=0. On mem_rvalid_i: IR<=mem_rdata_i, ir_we_o=1, pc_we_o=1, pc_src=0, a=PC, b=FOUR -> DECODE.
- DECODE: a=OLD_PC, b=IMM (branch/JAL target into ALUOUT). Opcode not in {R, IMMEDIATE, LOAD, STORE, BRANCH, JAL, LUI, AUIPC, SYSTEM} -> HALT, illegal_o=1.
- EXECUTE by IR opcode:
  - R: a=RS1, b=RS2, opcode/funct3/funct7 = IR fields -> WRITEBACK.
  - IMMEDIATE: a=RS1, b=IMM, IR fields passed (funct7 = IR[31:25]) -> WRITEBACK.
  - LOAD/STORE: a=RS1, b=IMM -> MEM_WAIT.
  - BRANCH: opcode_o=BRANCH, a=RS1, b=RS2; taken per funct3: 000 is_zero, 001 !is_zero, 100 is_less, 101 !is_less; if taken pc_we_o=1, pc_src=1 -> FETCH. funct3 010/011/110/111 -> HALT, illegal_o=1.
  - JAL: pc_we_o=1, pc_src=1; a=OLD_PC, b=FOUR -> WRITEBACK.
  - LUI: a=ZERO, b=IMM; AUIPC: a=OLD_PC, b=IMM -> WRITEBACK.
  - SYSTEM: -> HALT (illegal_o stays 0).
- MEM_WAIT: mem_req_o=1, addr_sel=ALUOUT, mem_we_o=1 for STORE. On rvalid: LOAD -> WRITEBACK (wb_sel=1), STORE -> FETCH.
- WRITEBACK: reg_we_o=(rd!=0), wb_sel per instruction -> FETCH.
- HALT: halt_o=1, no requests, sticky until reset.
- Immediates: I sext IR[31:20]; S sext{IR[31:25],IR[11:7]}; B sext{IR[31],IR[7],IR[30:25],IR[11:8],0}; U {IR[31:12],12'b0}; J sext{IR[31],IR[19:12],IR[20],IR[30:21],0}; R 0.

## Timing
- Reset: state=FETCH, IR=0, halt_o=0, illegal_o=0; outputs are Moore/decoded, so mem_req_o=1 with addr_sel=PC during and after reset (memory ignores requests while rst_ni=0); all other strobes 0.
- mem_req_o, mem_we_o, mem_addr_sel_o stable until rvalid sampled; rvalid in the first request cycle is legal (zero wait). rvalid outside FETCH/MEM_WAIT ignored.
- Zero-wait cycle counts: R/IMM/LUI/AUIPC/JAL 4, store 4, load 5, branch 3; each memory wait state adds 1.
- Flags sampled only in EXECUTE of BRANCH.
- Reset mid-operation: immediate return to FETCH, IR cleared, pending request abandoned.

## Test plan
- IR=addi x1,x0,5 (0x00500093), zero wait -> 4 cycles, EXECUTE a=RS1 b=IMM imm_o=5, reg_we_o=1 rd_o=1 in WRITEBACK.
- beq with is_zero_i=1 -> pc_we_o=1, pc_src_o=1 in EXECUTE; is_zero_i=0 -> no pc_we; 3 cycles each.
- lw with 3 wait states -> mem_req_o held, addr_sel=ALUOUT 4 cycles, WRITEBACK wb_sel=1, total 8 cycles.
- jal x1,-8 -> imm_o=0xFFFFFFF8, EXECUTE pc_we/pc_src=1 and a=OLD_PC b=FOUR, reg_we_o in WRITEBACK.
- ecall (0x00000073) -> halt_o=1 forever, mem_req_o=0; branch funct3=010 -> halt_o=1, illegal_o=1.
- rst_ni low during MEM_WAIT of sw -> next cycle after release FETCH, mem_we_o=0, IR=0.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle RV32 control FSM: owns the instruction register and immediate generator and
// sequences FETCH/DECODE/EXECUTE/MEM_WAIT/WRITEBACK over the datapath and unified memory port.
package params_pkg;
  parameter int DATA_WIDTH   = 32;
  parameter int OPCODE_WIDTH = 7;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IMM    = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_R      = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_SYSTEM = 7'b1110011
  } opcode_e;
endpackage

// state     | meaning
// S_FETCH   | request IR at PC; on rvalid capture IR and PC<=PC+4
// S_DECODE  | OLD_PC+IMM into ALUOUT (branch/JAL target); reject unknown opcodes
// S_EXECUTE | per-opcode ALU operation, branch resolution, JAL redirect
// S_MEM_WAIT| load/store request at ALUOUT until rvalid
// S_WRITEBACK| register-file write from ALUOUT or MDR
// S_HALT    | sticky stop after SYSTEM or illegal instruction
module control_unit
  import params_pkg::*;
#(
  parameter int DATA_WIDTH   = params_pkg::DATA_WIDTH,
  parameter int OPCODE_WIDTH = params_pkg::OPCODE_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_rvalid_i,
  input  logic                    is_zero_i,
  input  logic                    is_less_i,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic                    mem_addr_sel_o,
  output logic [OPCODE_WIDTH-1:0] opcode_o,
  output logic [2:0]              funct3_o,
  output logic [6:0]              funct7_o,
  output logic [1:0]              src_a_sel_o,
  output logic [1:0]              src_b_sel_o,
  output logic [DATA_WIDTH-1:0]   imm_o,
  output logic [4:0]              rs1_o,
  output logic [4:0]              rs2_o,
  output logic [4:0]              rd_o,
  output logic                    ir_we_o,
  output logic                    pc_we_o,
  output logic                    pc_src_o,
  output logic                    reg_we_o,
  output logic                    wb_sel_o,
  output logic                    halt_o,
  output logic                    illegal_o
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM_WAIT, S_WRITEBACK, S_HALT
  } state_e;

  localparam logic [1:0] A_PC = 2'b00, A_OLD_PC = 2'b01, A_RS1 = 2'b10, A_ZERO = 2'b11;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   ir_q, ir_d;
  logic                    illegal_q, illegal_d;

  logic [6:0] ir_op;
  logic [2:0] ir_funct3;
  logic [6:0] ir_funct7;
  logic       op_legal;
  logic       br_legal;
  logic       br_taken;
  logic [6:0] alu_op;

  assign ir_op     = ir_q[6:0];
  assign ir_funct3 = ir_q[14:12];
  assign ir_funct7 = ir_q[31:25];
  assign rs1_o     = ir_q[19:15];
  assign rs2_o     = ir_q[24:20];
  assign rd_o      = ir_q[11:7];

  always_comb begin
    op_legal = 1'b0;
    case (ir_op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM: op_legal = 1'b1;
      default:                             op_legal = 1'b0;
    endcase
  end

  // Only BEQ/BNE/BLT/BGE are decoded; the unsigned variants are not supported by the flags.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (ir_funct3)
      3'b000:  br_taken = is_zero_i;
      3'b001:  br_taken = !is_zero_i;
      3'b100:  br_taken = is_less_i;
      3'b101:  br_taken = !is_less_i;
      default: br_legal = 1'b0;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (ir_op)
      OP_IMM, OP_LOAD, OP_SYSTEM: imm_o = {{20{ir_q[31]}}, ir_q[31:20]};
      OP_STORE:                   imm_o = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      OP_BRANCH:                  imm_o = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:           imm_o = {ir_q[31:12], 12'b0};
      OP_JAL:                     imm_o = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default:                    imm_o = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (mem_rvalid_i) begin
          ir_d    = mem_rdata_i;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXECUTE: begin
        case (ir_op)
          OP_R, OP_IMM, OP_JAL, OP_LUI, OP_AUIPC: state_d = S_WRITEBACK;
          OP_LOAD, OP_STORE:                      state_d = S_MEM_WAIT;
          OP_BRANCH: begin
            if (br_legal) begin
              state_d = S_FETCH;
            end else begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM_WAIT: begin
        if (mem_rvalid_i) state_d = (ir_op == OP_LOAD) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_addr_sel_o = 1'b0;
    alu_op         = OP_LOAD;
    funct3_o       = 3'b000;
    funct7_o       = 7'b0;
    src_a_sel_o    = A_PC;
    src_b_sel_o    = B_RS2;
    ir_we_o        = 1'b0;
    pc_we_o        = 1'b0;
    pc_src_o       = 1'b0;
    reg_we_o       = 1'b0;
    wb_sel_o       = 1'b0;
    halt_o         = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_rvalid_i) begin
          ir_we_o     = 1'b1;
          pc_we_o     = 1'b1;
          src_b_sel_o = B_FOUR;
        end
      end
      S_DECODE: begin
        src_a_sel_o = A_OLD_PC;
        src_b_sel_o = B_IMM;
      end
      S_EXECUTE: begin
        case (ir_op)
          OP_R: begin
            src_a_sel_o = A_RS1;
            src_b_sel_o = B_RS2;
            alu_op      = ir_op;
            funct3_o    = ir_funct3;
            funct7_o    = ir_funct7;
          end
          OP_IMM: begin
            src_a_sel_o = A_RS1;
            src_b_sel_o = B_IMM;
            alu_op      = ir_op;
            funct3_o    = ir_funct3;
            funct7_o    = ir_funct7;
          end
          OP_LOAD, OP_STORE: begin
            src_a_sel_o = A_RS1;
            src_b_sel_o = B_IMM;
          end
          OP_BRANCH: begin
            alu_op      = OP_BRANCH;
            src_a_sel_o = A_RS1;
            src_b_sel_o = B_RS2;
            if (br_taken) begin
              pc_we_o  = 1'b1;
              pc_src_o = 1'b1;
            end
          end
          OP_JAL: begin
            pc_we_o     = 1'b1;
            pc_src_o    = 1'b1;
            src_a_sel_o = A_OLD_PC;
            src_b_sel_o = B_FOUR;
          end
          OP_LUI: begin
            src_a_sel_o = A_ZERO;
            src_b_sel_o = B_IMM;
          end
          OP_AUIPC: begin
            src_a_sel_o = A_OLD_PC;
            src_b_sel_o = B_IMM;
          end
          default: ;
        endcase
      end
      S_MEM_WAIT: begin
        mem_req_o      = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o       = (ir_op == OP_STORE);
      end
      S_WRITEBACK: begin
        reg_we_o = (rd_o != 5'd0);
        wb_sel_o = (ir_op == OP_LOAD);
      end
      S_HALT:  halt_o = 1'b1;
      default: ;
    endcase
  end

  assign opcode_o  = OPCODE_WIDTH'(alu_op);
  assign illegal_o = illegal_q;

endmodule
